// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM/WB write-back stage.
//   wb_sel_e : write-back source select (ALU result, load data, PC+4, reserved)
//   F3_*     : load funct3 encodings consumed by the load extender
//   XLEN_DEF : default datapath width
package wb_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_writeback_stage_if.sv
// Bundle between the MEM stage / hazard unit and the write-back stage.
//   master : drives stall/flush and the in_* fields, observes the write port
//   slave  : the write-back stage itself
// Write port (RegWEn/rd_add/dataW), forwarding tap (fwd_*) and the retire
// counter travel back on the same bundle.
interface wb_writeback_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             stall;
    logic             flush;
    logic             in_valid;
    logic             in_RegWEn;
    logic [4:0]       in_rd_add;
    logic [1:0]       in_wb_sel;
    logic [2:0]       in_funct3;
    logic [1:0]       in_byte_off;
    logic [XLEN-1:0]  in_alu_result;
    logic [XLEN-1:0]  in_mem_rdata;
    logic [XLEN-1:0]  in_pc_plus4;

    logic             RegWEn;
    logic [4:0]       rd_add;
    logic [XLEN-1:0]  dataW;
    logic             fwd_valid;
    logic [4:0]       fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output stall, flush, in_valid, in_RegWEn, in_rd_add, in_wb_sel,
               in_funct3, in_byte_off, in_alu_result, in_mem_rdata, in_pc_plus4,
        input  RegWEn, rd_add, dataW, fwd_valid, fwd_rd, fwd_data, retire_count
    );

    modport slave (
        input  stall, flush, in_valid, in_RegWEn, in_rd_add, in_wb_sel,
               in_funct3, in_byte_off, in_alu_result, in_mem_rdata, in_pc_plus4,
        output RegWEn, rd_add, dataW, fwd_valid, fwd_rd, fwd_data, retire_count
    );

endinterface

// File: rtl/wb_writeback_stage_load_extend.sv
// Combinational load extender: picks the byte/halfword addressed by the low
// address bits out of the raw memory word and sign- or zero-extends it.
//   rdata_i    : raw word from data memory
//   funct3_i   : load type
//   byte_off_i : load address bits [1:0]
//   ext_o      : extended result
// Unknown funct3 codes fall through to a full-word load.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      byte_off_i,
    output logic [XLEN-1:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (byte_off_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        // Only bit 1 picks the halfword; a misaligned bit 0 is ignored.
        half_sel = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        ext_o = rdata_i;
        case (funct3_i)
            F3_LB:   ext_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  ext_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   ext_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  ext_o = {{(XLEN-16){1'b0}}, half_sel};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_writeback_stage.sv
// MEM/WB pipeline register plus write-back mux.
//   clk   : pipeline clock
//   rst_n : asynchronous active-low reset, clears stage and retire counter
//   wb    : slave side of the stage bundle (stall/flush, in_* capture fields,
//           register-file write port, forwarding tap, retire counter)
// Write port outputs are combinational from the stage registers, so a value
// captured at edge N is presented during cycle N and committed at edge N+1.
module wb_writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_writeback_stage_if.slave   wb
);

    logic             valid_q;
    logic             regwen_q;
    logic [4:0]       rd_q;
    wb_sel_e          wb_sel_q;
    logic [2:0]       funct3_q;
    logic [1:0]       byte_off_q;
    logic [XLEN-1:0]  alu_q;
    logic [XLEN-1:0]  rdata_q;
    logic [XLEN-1:0]  pc4_q;
    logic [CNT_W-1:0] retire_count_q;
    logic [CNT_W-1:0] retire_count_d;

    logic [XLEN-1:0]  load_ext;
    logic             wr_en;
    logic [XLEN-1:0]  wr_data;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata_i    (rdata_q),
        .funct3_i   (funct3_q),
        .byte_off_i (byte_off_q),
        .ext_o      (load_ext)
    );

    // The held instruction departs whenever the stage is not holding it:
    // a flush overrides stall, so the flushed-out instruction still retires.
    always_comb begin
        retire_count_d = retire_count_q;
        if (valid_q && (!wb.stall || wb.flush)) begin
            retire_count_d = retire_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= 1'b0;
            regwen_q       <= 1'b0;
            rd_q           <= '0;
            wb_sel_q       <= WB_ALU;
            funct3_q       <= '0;
            byte_off_q     <= '0;
            alu_q          <= '0;
            rdata_q        <= '0;
            pc4_q          <= '0;
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
            if (wb.flush) begin
                valid_q <= 1'b0;
            end else if (!wb.stall) begin
                valid_q    <= wb.in_valid;
                regwen_q   <= wb.in_RegWEn;
                rd_q       <= wb.in_rd_add;
                wb_sel_q   <= wb_sel_e'(wb.in_wb_sel);
                funct3_q   <= wb.in_funct3;
                byte_off_q <= wb.in_byte_off;
                alu_q      <= wb.in_alu_result;
                rdata_q    <= wb.in_mem_rdata;
                pc4_q      <= wb.in_pc_plus4;
            end
        end
    end

    // x0 is hard-wired zero and the reserved select never writes.
    assign wr_en = valid_q & regwen_q & (rd_q != 5'd0) & (wb_sel_q != WB_RSVD);

    always_comb begin
        wr_data = '0;
        case (wb_sel_q)
            WB_ALU:  wr_data = alu_q;
            WB_MEM:  wr_data = load_ext;
            WB_PC4:  wr_data = pc4_q;
            default: wr_data = '0;
        endcase
    end

    assign wb.RegWEn       = wr_en;
    assign wb.rd_add       = rd_q;
    assign wb.dataW        = wr_data;
    // Forwarding tap mirrors the write port so EX sees the value being written.
    assign wb.fwd_valid    = wr_en;
    assign wb.fwd_rd       = rd_q;
    assign wb.fwd_data     = wr_data;
    assign wb.retire_count = retire_count_q;

endmodule

// File: tb/tb_wb_writeback_stage.sv
// Scoreboard bench for wb_writeback_stage: each directed vector pushes its
// hand-computed write-port expectation; a negedge monitor pops and compares.
module tb_wb_writeback_stage;

    logic clk;
    logic rst_n;

    wb_writeback_stage_if #(.XLEN(32), .CNT_W(32)) bus ();

    wb_writeback_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference count of retired instructions (tracks what the stage holds).
    logic        m_valid = 1'b0;
    logic [31:0] m_cnt   = 32'd0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("RegWEn", e.id, {31'd0, bus.RegWEn}, {31'd0, e.we});
            chk("fwd_valid", e.id, {31'd0, bus.fwd_valid}, {31'd0, e.we});
            chk("retire_count", e.id, bus.retire_count, e.cnt);
            if (e.chk) begin
                chk("rd_add", e.id, {27'd0, bus.rd_add}, {27'd0, e.rd});
                chk("dataW", e.id, bus.dataW, e.data);
                chk("fwd_rd", e.id, {27'd0, bus.fwd_rd}, {27'd0, e.rd});
                chk("fwd_data", e.id, bus.fwd_data, e.data);
            end
            $display("vec %0d: we=%0b rd=%0d data=%h cnt=%0d", e.id, bus.RegWEn, bus.rd_add, bus.dataW, bus.retire_count);
        end
    end

    task automatic apply(input int id, input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc4,
                         input logic st, input logic fl,
                         input logic ewe, input logic [4:0] erd, input logic [31:0] edata, input logic echk);
        exp_t e;
        bus.in_valid      = v;
        bus.in_RegWEn     = we;
        bus.in_rd_add     = rd;
        bus.in_wb_sel     = sel;
        bus.in_funct3     = f3;
        bus.in_byte_off   = off;
        bus.in_alu_result = alu;
        bus.in_mem_rdata  = rdat;
        bus.in_pc_plus4   = pc4;
        bus.stall         = st;
        bus.flush         = fl;
        @(posedge clk);
        if (m_valid && (!st || fl)) m_cnt = m_cnt + 1;
        if (fl) m_valid = 1'b0;
        else if (!st) m_valid = v;
        e.id = id; e.we = ewe; e.rd = erd; e.data = edata; e.chk = echk; e.cnt = m_cnt;
        sb.push_back(e);
        #1;
    endtask

    task automatic check_zero(input int id);
        chk("rst_RegWEn", id, {31'd0, bus.RegWEn}, 32'd0);
        chk("rst_fwd_valid", id, {31'd0, bus.fwd_valid}, 32'd0);
        chk("rst_rd_add", id, {27'd0, bus.rd_add}, 32'd0);
        chk("rst_dataW", id, bus.dataW, 32'd0);
        chk("rst_retire_count", id, bus.retire_count, 32'd0);
    endtask

    localparam logic [31:0] LD = 32'h80F17F01;

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_RegWEn = 1'b0;
        bus.in_rd_add = '0; bus.in_wb_sel = '0; bus.in_funct3 = '0; bus.in_byte_off = '0;
        bus.in_alu_result = '0; bus.in_mem_rdata = '0; bus.in_pc_plus4 = '0;
        #2;
        check_zero(100);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        //     id v  we rd     sel    f3      off    alu           rdata  pc4           st    fl    ewe   erd    edata         chk
        apply(0, 1, 1, 5'd3, 2'b00, 3'b000, 2'd0, 32'h12345678, LD, 32'h0,   1'b0, 1'b0, 1'b1, 5'd3, 32'h12345678, 1'b1);
        apply(1, 1, 1, 5'd4, 2'b01, 3'b000, 2'd3, 32'h0, LD, 32'h0,          1'b0, 1'b0, 1'b1, 5'd4, 32'hFFFFFF80, 1'b1);
        apply(2, 1, 1, 5'd4, 2'b01, 3'b100, 2'd3, 32'h0, LD, 32'h0,          1'b0, 1'b0, 1'b1, 5'd4, 32'h00000080, 1'b1);
        apply(3, 1, 1, 5'd4, 2'b01, 3'b001, 2'd2, 32'h0, LD, 32'h0,          1'b0, 1'b0, 1'b1, 5'd4, 32'hFFFF80F1, 1'b1);
        apply(4, 1, 1, 5'd4, 2'b01, 3'b101, 2'd0, 32'h0, LD, 32'h0,          1'b0, 1'b0, 1'b1, 5'd4, 32'h00007F01, 1'b1);
        apply(5, 1, 1, 5'd4, 2'b01, 3'b010, 2'd1, 32'h0, LD, 32'h0,          1'b0, 1'b0, 1'b1, 5'd4, 32'h80F17F01, 1'b1);
        apply(6, 1, 1, 5'd6, 2'b01, 3'b000, 2'd1, 32'h0, LD, 32'h0,          1'b0, 1'b0, 1'b1, 5'd6, 32'h0000007F, 1'b1);
        apply(7, 1, 1, 5'd6, 2'b01, 3'b001, 2'd3, 32'h0, LD, 32'h0,          1'b0, 1'b0, 1'b1, 5'd6, 32'hFFFF80F1, 1'b1);
        apply(8, 1, 1, 5'd0, 2'b00, 3'b000, 2'd0, 32'h5, LD, 32'h0,          1'b0, 1'b0, 1'b0, 5'd0, 32'h00000005, 1'b1);
        apply(9, 1, 1, 5'd7, 2'b11, 3'b000, 2'd0, 32'h5, LD, 32'h0,          1'b0, 1'b0, 1'b0, 5'd7, 32'h00000000, 1'b1);
        apply(10, 1, 1, 5'd5, 2'b10, 3'b000, 2'd0, 32'h9, LD, 32'h104,       1'b0, 1'b0, 1'b1, 5'd5, 32'h00000104, 1'b1);
        for (int i = 0; i < 3; i++)
            apply(11 + i, 1, 1, 5'd9, 2'b00, 3'b000, 2'd0, 32'hDEAD0000 + i, LD, 32'h200, 1'b1, 1'b0, 1'b1, 5'd5, 32'h00000104, 1'b1);
        apply(14, 1, 1, 5'd9, 2'b00, 3'b000, 2'd0, 32'hDEAD0000, LD, 32'h200, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        apply(15, 0, 0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0, LD, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        apply(16, 1, 1, 5'd12, 2'b00, 3'b000, 2'd0, 32'h000000AA, LD, 32'h0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h000000AA, 1'b1);

        // Asynchronous reset between edges while a write is being presented.
        @(negedge clk); #1;
        chk("pre_rst_RegWEn", 101, {31'd0, bus.RegWEn}, 32'd1);
        rst_n = 1'b0;
        m_valid = 1'b0; m_cnt = 32'd0;
        #1;
        check_zero(102);
        bus.in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check_zero(103);
        $display("async reset: we=%0b rd=%0d data=%h cnt=%0d", bus.RegWEn, bus.rd_add, bus.dataW, bus.retire_count);
        @(posedge clk); #1;
        apply(17, 0, 0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0, LD, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        apply(18, 1, 1, 5'd3, 2'b00, 3'b000, 2'd0, 32'h00000077, LD, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h00000077, 1'b1);
        apply(19, 0, 0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0, LD, 32'h0,         1'b0, 1'b0, 1'b0, 5'd3, 32'h00000077, 1'b0);

        begin
            int budget;
            budget = 0;
            while (sb.size() > 0 && budget < 10) begin
                @(posedge clk);
                budget++;
            end
            if (sb.size() > 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain pending=%0d required=0", sb.size());
            end
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached=100000ns required=finish");
        $fatal(1, "timeout");
    end

endmodule
